// File: rtl/reg_file_2w2r_if.sv
// Bus bundle for the dual-write / dual-read register file.
// The master drives writes and read requests; the slave returns read data.
interface reg_file_2w2r_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  localparam int NB = DATA_W / 8;

  logic              en;

  logic              wr_en0;
  logic [ADDR_W-1:0] wr_addr0;
  logic [DATA_W-1:0] wr_data0;
  logic [NB-1:0]     wr_be0;

  logic              wr_en1;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data1;
  logic [NB-1:0]     wr_be1;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid;

  modport master (
    output en,
    output wr_en0, wr_addr0, wr_data0, wr_be0,
    output wr_en1, wr_addr1, wr_data1, wr_be1,
    output rd_en, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_valid
  );

  modport slave (
    input  en,
    input  wr_en0, wr_addr0, wr_data0, wr_be0,
    input  wr_en1, wr_addr1, wr_data1, wr_be1,
    input  rd_en, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_valid
  );
endinterface

// File: rtl/reg_file_2w2r.sv
// General-purpose operand store: 2 byte-masked write ports (port 1 wins
// per byte on collision), 2 registered read ports sharing one rd_en,
// optional write-to-read bypass and optional hardwired zero entry.
module reg_file_2w2r #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic            clk,
  input  logic            rst,
  reg_file_2w2r_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  // Current contents and the contents after this cycle's writes, per entry.
  // mem_d is what the bypass path forwards.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        // Hardwired zero: no storage, writes are dropped.
        assign mem_q[gi] = '0;
        assign mem_d[gi] = '0;
      end else begin : g_rw
        logic              hit0;
        logic              hit1;
        logic [DATA_W-1:0] word_q;
        logic [DATA_W-1:0] word_d;

        // Writes only land when globally enabled.
        assign hit0 = bus.en & bus.wr_en0 & (bus.wr_addr0 == ADDR_W'(gi));
        assign hit1 = bus.en & bus.wr_en1 & (bus.wr_addr1 == ADDR_W'(gi));

        // Per-byte merge of both ports; port 1 takes precedence on a shared byte.
        always_comb begin
          word_d = word_q;
          for (int b = 0; b < NB; b++) begin
            if (hit1 && bus.wr_be1[b]) begin
              word_d[8*b +: 8] = bus.wr_data1[8*b +: 8];
            end else if (hit0 && bus.wr_be0[b]) begin
              word_d[8*b +: 8] = bus.wr_data0[8*b +: 8];
            end
          end
        end

        // Entry storage, cleared by reset.
        always_ff @(posedge clk) begin
          if (rst) begin
            word_q <= '0;
          end else begin
            word_q <= word_d;
          end
        end

        assign mem_q[gi] = word_q;
        assign mem_d[gi] = word_d;
      end
    end
  endgenerate

  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              rd_valid_q,  rd_valid_d;

  // Select the value a read port sees: post-write with bypass, stored otherwise.
  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] w;
    if (BYPASS != 0) begin
      w = mem_d[addr];
    end else begin
      w = mem_q[addr];
    end
    if ((ZERO_REG != 0) && (addr == '0)) begin
      w = '0;
    end
    return w;
  endfunction

  // Read port next-state: load on an enabled read, otherwise hold; valid pulses.
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    rd_valid_d  = 1'b0;
    if (bus.en && bus.rd_en) begin
      rd_data_a_d = read_word(bus.rd_addr_a);
      rd_data_b_d = read_word(bus.rd_addr_b);
      rd_valid_d  = 1'b1;
    end
  end

  // Read output registers; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign bus.rd_data_a = rd_data_a_q;
  assign bus.rd_data_b = rd_data_b_q;
  assign bus.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Directed bench for reg_file_2w2r. Two instances run on identical stimulus:
// dut_a (BYPASS=1, ZERO_REG=0) and dut_b (BYPASS=0, ZERO_REG=1).
module tb_reg_file_2w2r;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_2w2r_if #(.DATA_W(32), .ADDR_W(4)) bus_a ();
  reg_file_2w2r_if #(.DATA_W(32), .ADDR_W(4)) bus_b ();

  // dut_b mirrors the inputs driven onto bus_a
  assign bus_b.en        = bus_a.en;
  assign bus_b.wr_en0    = bus_a.wr_en0;
  assign bus_b.wr_addr0  = bus_a.wr_addr0;
  assign bus_b.wr_data0  = bus_a.wr_data0;
  assign bus_b.wr_be0    = bus_a.wr_be0;
  assign bus_b.wr_en1    = bus_a.wr_en1;
  assign bus_b.wr_addr1  = bus_a.wr_addr1;
  assign bus_b.wr_data1  = bus_a.wr_data1;
  assign bus_b.wr_be1    = bus_a.wr_be1;
  assign bus_b.rd_en     = bus_a.rd_en;
  assign bus_b.rd_addr_a = bus_a.rd_addr_a;
  assign bus_b.rd_addr_b = bus_a.rd_addr_b;

  reg_file_2w2r #(.DATA_W(32), .ADDR_W(4), .BYPASS(1), .ZERO_REG(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  reg_file_2w2r #(.DATA_W(32), .ADDR_W(4), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    string       name;
    logic        en;
    logic        we0;
    logic [3:0]  wa0;
    logic [31:0] wd0;
    logic [3:0]  be0;
    logic        we1;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic [3:0]  be1;
    logic        re;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] a_da;
    logic [31:0] a_db;
    logic        a_v;
    logic [31:0] b_da;
    logic [31:0] b_db;
    logic        b_v;
  } vec_t;

  vec_t vecs [14];

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm,
                         input logic [31:0] a_da, input logic [31:0] a_db, input logic a_v,
                         input logic [31:0] b_da, input logic [31:0] b_db, input logic b_v);
    chk({nm, "/a.rd_data_a"}, bus_a.rd_data_a, a_da);
    chk({nm, "/a.rd_data_b"}, bus_a.rd_data_b, a_db);
    chk({nm, "/a.rd_valid"},  {31'd0, bus_a.rd_valid}, {31'd0, a_v});
    chk({nm, "/b.rd_data_a"}, bus_b.rd_data_a, b_da);
    chk({nm, "/b.rd_data_b"}, bus_b.rd_data_b, b_db);
    chk({nm, "/b.rd_valid"},  {31'd0, bus_b.rd_valid}, {31'd0, b_v});
  endtask

  task automatic drive(input logic en,
                       input logic we0, input logic [3:0] wa0, input logic [31:0] wd0, input logic [3:0] be0,
                       input logic we1, input logic [3:0] wa1, input logic [31:0] wd1, input logic [3:0] be1,
                       input logic re, input logic [3:0] ra, input logic [3:0] rb);
    bus_a.en        = en;
    bus_a.wr_en0    = we0;
    bus_a.wr_addr0  = wa0;
    bus_a.wr_data0  = wd0;
    bus_a.wr_be0    = be0;
    bus_a.wr_en1    = we1;
    bus_a.wr_addr1  = wa1;
    bus_a.wr_data1  = wd1;
    bus_a.wr_be1    = be1;
    bus_a.rd_en     = re;
    bus_a.rd_addr_a = ra;
    bus_a.rd_addr_b = rb;
  endtask

  initial begin
    //          name         en   we0  wa0   wd0            be0   we1  wa1   wd1            be1   re   ra    rb     a_da           a_db           a_v   b_da           b_db           b_v
    vecs[0]  = '{"be_full",  1'b1, 1'b1, 4'd3, 32'hABCD_EFAB, 4'hF, 1'b0, 4'd0, 32'h0,         4'h0, 1'b0, 4'd0, 4'd0,  32'h0,         32'h0,         1'b0, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{"be_part",  1'b1, 1'b1, 4'd3, 32'h1122_3344, 4'h5, 1'b0, 4'd0, 32'h0,         4'h0, 1'b0, 4'd0, 4'd0,  32'h0,         32'h0,         1'b0, 32'h0,         32'h0,         1'b0};
    vecs[2]  = '{"be_read",  1'b1, 1'b0, 4'd0, 32'h0,         4'h0, 1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd3, 4'd3,  32'hAB22_EF44, 32'hAB22_EF44, 1'b1, 32'hAB22_EF44, 32'hAB22_EF44, 1'b1};
    vecs[3]  = '{"collide",  1'b1, 1'b1, 4'd5, 32'h0123_4567, 4'hF, 1'b1, 4'd5, 32'h89AB_CDEF, 4'h3, 1'b0, 4'd0, 4'd0,  32'hAB22_EF44, 32'hAB22_EF44, 1'b0, 32'hAB22_EF44, 32'hAB22_EF44, 1'b0};
    vecs[4]  = '{"coll_rd",  1'b1, 1'b0, 4'd0, 32'h0,         4'h0, 1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd5, 4'd5,  32'h0123_CDEF, 32'h0123_CDEF, 1'b1, 32'h0123_CDEF, 32'h0123_CDEF, 1'b1};
    vecs[5]  = '{"seed7",    1'b1, 1'b1, 4'd7, 32'h0000_0001, 4'hF, 1'b0, 4'd0, 32'h0,         4'h0, 1'b0, 4'd0, 4'd0,  32'h0123_CDEF, 32'h0123_CDEF, 1'b0, 32'h0123_CDEF, 32'h0123_CDEF, 1'b0};
    vecs[6]  = '{"bypass",   1'b1, 1'b1, 4'd7, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd7, 4'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b1};
    vecs[7]  = '{"after_bp", 1'b1, 1'b0, 4'd0, 32'h0,         4'h0, 1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd7, 4'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[8]  = '{"bp_merge", 1'b1, 1'b1, 4'd9, 32'h1111_1111, 4'hF, 1'b1, 4'd9, 32'h2222_2222, 4'h8, 1'b1, 4'd9, 4'd3,  32'h2211_1111, 32'hAB22_EF44, 1'b1, 32'h0,         32'hAB22_EF44, 1'b1};
    vecs[9]  = '{"zero_wr",  1'b1, 1'b1, 4'd0, 32'h5555_5555, 4'hF, 1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd0, 4'd0,  32'h5555_5555, 32'h5555_5555, 1'b1, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{"zero_rd",  1'b1, 1'b0, 4'd0, 32'h0,         4'h0, 1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd0, 4'd9,  32'h5555_5555, 32'h2211_1111, 1'b1, 32'h0,         32'h2211_1111, 1'b1};
    vecs[11] = '{"zero_p1",  1'b1, 1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd0, 32'hAAAA_AAAA, 4'hF, 1'b1, 4'd0, 4'd0,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 32'h0,         32'h0,         1'b1};
    vecs[12] = '{"idle",     1'b1, 1'b0, 4'd0, 32'h0,         4'h0, 1'b0, 4'd0, 32'h0,         4'h0, 1'b0, 4'd0, 4'd0,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, 32'h0,         32'h0,         1'b0};
    vecs[13] = '{"bp_other", 1'b1, 1'b1, 4'd2, 32'hCAFE_F00D, 4'hF, 1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd2, 4'd7,  32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b1, 32'h0,         32'hDEAD_BEEF, 1'b1};

    // Reset state
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 4'd0);
    tick();
    tick();
    chk_all("reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    // Fill every entry with ones, then read one back
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 4'(i), 32'hFFFF_FFFF, 4'hF, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 4'd0);
      tick();
    end
    drive(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd4, 4'd4);
    tick();
    chk_all("fill_rd", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    // Reset with a read pending: result discarded
    rst = 1'b1;
    tick();
    chk_all("rst_mid", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    // Every entry reads zero after reset
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i), 4'(15 - i));
      tick();
      chk_all($sformatf("clr_%0d", i), 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1);
    end

    // Table-driven vectors, one clock each
    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].en, vecs[v].we0, vecs[v].wa0, vecs[v].wd0, vecs[v].be0,
            vecs[v].we1, vecs[v].wa1, vecs[v].wd1, vecs[v].be1,
            vecs[v].re, vecs[v].ra, vecs[v].rb);
      tick();
      chk_all(vecs[v].name, vecs[v].a_da, vecs[v].a_db, vecs[v].a_v,
              vecs[v].b_da, vecs[v].b_db, vecs[v].b_v);
    end

    // Enable freeze
    drive(1'b1, 1'b1, 4'd1, 32'h0123_4567, 4'hF, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 4'd0);
    tick();
    chk_all("frz_wr", 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd1, 4'd1);
    tick();
    chk_all("frz_rd", 32'h0123_4567, 32'h0123_4567, 1'b1, 32'h0123_4567, 32'h0123_4567, 1'b1);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 4'd1, 32'h0, 4'hF, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd2, 4'd2);
      tick();
      chk_all($sformatf("frz_%0d", c), 32'h0123_4567, 32'h0123_4567, 1'b0,
              32'h0123_4567, 32'h0123_4567, 1'b0);
    end
    drive(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd1, 4'd2);
    tick();
    chk_all("frz_after", 32'h0123_4567, 32'hCAFE_F00D, 1'b1, 32'h0123_4567, 32'hCAFE_F00D, 1'b1);
    drive(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 4'd0);
    tick();
    chk_all("end_idle", 32'h0123_4567, 32'hCAFE_F00D, 1'b0, 32'h0123_4567, 32'hCAFE_F00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
